// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 3-sample majority vote per bit, parity/framing checks,
// one-entry valid/ready holding register. Define UART_RX_BREAK_DETECT_EN for break detection.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_frame_err,
    output logic                 m_parity_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int MID          = CLKS_PER_BIT / 2;
    localparam int CCW          = $clog2(CLKS_PER_BIT + 1);
    localparam int BCW          = $clog2(DATA_BITS);
    localparam logic [CCW-1:0] CC_LAST = CCW'(CLKS_PER_BIT - 1);
    localparam logic [CCW-1:0] CC_S0   = CCW'(MID - 1);
    localparam logic [CCW-1:0] CC_S1   = CCW'(MID);
    localparam logic [CCW-1:0] CC_S2   = CCW'(MID + 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
`ifdef UART_RX_BREAK_DETECT_EN
        , S_BRK_WAIT = 3'd5
`endif
    } state_t;

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic pb);
        logic x;
        x = (^d) ^ pb;
        if (PARITY == 1)      return ~x;
        else if (PARITY == 2) return x;
        else                  return 1'b0;
    endfunction

    state_t                 state_q, state_d;
    logic                   sync1_q, rs_q;
    logic [CCW-1:0]         cc_q, cc_d;
    logic [BCW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [1:0]             samp_q, samp_d;
    logic                   par_bit_q, par_bit_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   m_data_q;
    logic                   m_valid_q, m_ferr_q, m_perr_q, overrun_q, break_q, busy_q;
    logic                   vote_s, at_vote_s, cell_end_s, push_s, brk_s;

    assign vote_s     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rs_q) | (samp_q[1] & rs_q);
    assign at_vote_s  = (cc_q == CC_S2);
    assign cell_end_s = (cc_q == CC_LAST);

    // Synchroniser, bit-timing and frame state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rs_q      <= 1'b1;
            state_q   <= S_IDLE;
            cc_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            samp_q    <= 2'b00;
            par_bit_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx;
            rs_q      <= sync1_q;
            state_q   <= state_d;
            cc_q      <= cc_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            par_bit_q <= par_bit_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic: samples at MID-1/MID are stored, the vote uses the live sample at MID+1
    always_comb begin
        state_d   = state_q;
        cc_d      = cc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        samp_d    = samp_q;
        par_bit_d = par_bit_q;
        ferr_d    = ferr_q;
        push_s    = 1'b0;
        brk_s     = 1'b0;
        if (cc_q == CC_S0)      samp_d[0] = rs_q;
        else if (cc_q == CC_S1) samp_d[1] = rs_q;
        else                    samp_d    = samp_q;
        case (state_q)
            S_IDLE: begin
                cc_d = '0;
                if (!rs_q) begin
                    state_d   = S_START;
                    cc_d      = CCW'(1);
                    bit_d     = '0;
                    ferr_d    = 1'b0;
                    par_bit_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (at_vote_s && vote_s) begin
                    state_d = S_IDLE;
                    cc_d    = '0;
                end else if (cell_end_s) begin
                    state_d = S_DATA;
                    cc_d    = '0;
                    bit_d   = '0;
                end else begin
                    cc_d = cc_q + CCW'(1);
                end
            end
            S_DATA: begin
                if (at_vote_s) shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                else           shift_d = shift_q;
                if (cell_end_s) begin
                    cc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BCW'(1);
                    end
                end else begin
                    cc_d = cc_q + CCW'(1);
                end
            end
            S_PARITY: begin
                if (at_vote_s) par_bit_d = vote_s;
                else           par_bit_d = par_bit_q;
                if (cell_end_s) begin
                    cc_d    = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cc_d = cc_q + CCW'(1);
                end
            end
            S_STOP: begin
                if (at_vote_s) begin
                    ferr_d = ferr_q | ~vote_s;
`ifdef UART_RX_BREAK_DETECT_EN
                    if (bit_q == '0 && shift_q == '0 && !par_bit_q && !vote_s) begin
                        brk_s   = 1'b1;
                        state_d = S_BRK_WAIT;
                        cc_d    = '0;
                    end else
`endif
                    if (bit_q == STOP_LAST) begin
                        push_s  = 1'b1;
                        state_d = S_IDLE;
                        cc_d    = '0;
                    end else begin
                        cc_d = cc_q + CCW'(1);
                    end
                end else if (cell_end_s) begin
                    cc_d  = '0;
                    bit_d = bit_q + BCW'(1);
                end else begin
                    cc_d = cc_q + CCW'(1);
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            // Leave only after a full bit time of continuous idle line
            S_BRK_WAIT: begin
                if (!rs_q) begin
                    cc_d = '0;
                end else if (cell_end_s) begin
                    state_d = S_IDLE;
                    cc_d    = '0;
                end else begin
                    cc_d = cc_q + CCW'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cc_d    = '0;
            end
        endcase
    end

    // Holding register: a push while the old word is still pending is dropped as overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_ferr_q  <= 1'b0;
            m_perr_q  <= 1'b0;
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            break_q   <= brk_s;
            busy_q    <= (state_d != S_IDLE);
            if (push_s) begin
                if (!m_valid_q || m_ready) begin
                    m_data_q  <= shift_q;
                    m_ferr_q  <= ferr_q | ~vote_s;
                    m_perr_q  <= parity_bad(shift_q, par_bit_q);
                    m_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end else begin
                m_valid_q <= m_valid_q;
            end
        end
    end

    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_frame_err  = m_ferr_q;
    assign m_parity_err = m_perr_q;
    assign overrun      = overrun_q;
    assign break_det    = break_q;
    assign busy         = busy_q;

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the inference front-end.
- Configurable data width, parity and stop-bit count.
- Majority-vote sampling per bit, with framing and parity error reporting.
- Valid/ready output backed by a one-entry holding register with overrun detection.
- Feeds the weight/image loader byte stream and any future wider-word or parity-protected host links.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz
BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), must be >= 8
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial line, idle high
m_data  out  DATA_BITS  received word, LSB = first bit on the line
m_valid  out  1  holding register holds an unconsumed word
m_ready  in  1  consumer accepts word when m_valid && m_ready
m_frame_err  out  1  stop-bit error flag for the word in m_data
m_parity_err  out  1  parity error flag for the word in m_data; 0 when PARITY=0
overrun  out  1  one-cycle pulse: a completed frame was dropped
break_det  out  1  one-cycle pulse on break (see Optional Feature)
busy  out  1  receiver is not in IDLE

Behaviour:
- Clock and reset: clk; rst is synchronous, active-high.
- Reset values: m_data=0, m_valid=0, both error flags=0, overrun=0, break_det=0, busy=0, FSM=IDLE.
  - Both synchroniser flops reset to 1.
  - rst asserted mid-frame aborts the frame; nothing is delivered.
- Synchronisation: rx passes through a 2-flop synchroniser (rs). All decisions use rs.
- Timing:
  - Bit cell = CLKS_PER_BIT clocks, counted by cell counter cc; MID = CLKS_PER_BIT/2.
  - Each bit samples rs at cc = MID-1, MID and MID+1. Bit value = majority of the 3 samples.
  - cc wraps to 0 at CLKS_PER_BIT-1 and steps to the next cell.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT (BRK_WAIT only with the macro).
  - IDLE: cc=0. When rs=0, go to START with cc=1 on the next cycle (the falling-edge clock counts as cc=0).
  - START: at cc=MID+1, evaluate the vote.
    - Vote 1: false start; return to IDLE with no flags.
    - Vote 0: continue; the next cell begins at the cc wrap.
  - DATA: capture DATA_BITS bits, LSB first, into a shift register.
    - Go to PARITY if PARITY != 0, else to STOP.
  - PARITY: compute XOR of data bits XOR the received parity bit.
    - Error when the result is 0 for odd parity or 1 for even parity.
  - STOP: each stop cell votes.
    - A 0 vote in any stop cell sets frame_err.
    - The frame completes at cc=MID+1 of the last stop cell; do not wait for the cell end.
    - Next cycle: state=IDLE, ready to detect a new start edge.
- Completion (one cycle, called "push"):
  - If m_valid=0, or m_valid && m_ready in the same cycle: load m_data and both error flags; m_valid=1.
  - If m_valid && !m_ready: discard the new word, keep the old word, pulse overrun=1 for 1 cycle.
- Handshake:
  - m_valid falls the cycle after m_valid && m_ready, unless a push happens in the same cycle.
  - m_data and the error flags are stable while m_valid && !m_ready.
- Latency: m_valid rises 1 clock after cc=MID+1 of the final stop cell.
- busy = (state != IDLE).

Optional Feature:
Macro UART_RX_BREAK_DETECT_EN.
- Defined:
  - Break condition: all data bits 0, the parity bit (if any) 0, and the first stop vote 0.
  - On break: no push; break_det pulses 1 for 1 cycle; FSM enters BRK_WAIT.
  - BRK_WAIT exits to IDLE only after rs=1 for a full CLKS_PER_BIT consecutive clocks.
- Undefined:
  - No BRK_WAIT state; break_det is tied 0.
  - A break frame is pushed as data 0 with m_frame_err=1 (m_parity_err as computed).
  - FSM returns to IDLE normally; a held-low line immediately starts a new frame.

Test Plan:
1. Defaults (868 clk/bit), send 0xA5 8N1, m_ready=1 → m_valid pulse, m_data=0xA5, both errors=0, m_valid at 1 clk after stop-cell cc=435.
2. PARITY=2 (even), send 0x07 with parity bit 0 (wrong) → m_data=0x07, m_parity_err=1; resend with parity 1 → m_parity_err=0.
3. Send 0x3C with stop bit 0 → m_data=0x3C, m_frame_err=1; a following valid 0x55 is received cleanly.
4. Hold m_ready=0, send 0x11 then 0x22 → m_data stays 0x11, overrun pulses once at the second completion. Then assert m_ready for 1 cycle → m_valid=0.
5. Glitch: rx low for 200 clks, then high → FSM returns to IDLE at cc=435, no push. Separately, inject a single-clock high spike at mid-bit in data bit 3 of 0x00 → received 0x00 (vote rejects it).
6. With UART_RX_BREAK_DETECT_EN: rx low for 3 frames → exactly one break_det pulse, no m_valid. After rx high for 868 clks, 0x5A is received correctly. Without the macro: push of 0x00 with m_frame_err=1.
